// File: rtl/shift_norm.sv
// rtl/shift_norm.sv - multi-cycle leading-zero / redundant-sign normalizer
//
// Purpose:
//   Shifts a captured operand left one bit per cycle until it is normalized,
//   reporting the applied shift amount. Mode 0 counts leading zeros
//   (unsigned). Mode 1 counts redundant sign bits (signed).
//
// Configuration macro:
//   SHIFT_NORM_SIGNED_EN - when defined, the mode input selects unsigned or
//   signed normalization. When undefined, mode is ignored, only leading-zero
//   normalization exists and the sign-compare logic is not built.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   request, sampled only while idle
//   mode      in   0 = leading zeros, 1 = redundant sign bits
//   data_in   in   operand, captured on the accepting edge
//   busy      out  high while shifting and during the done cycle
//   done      out  one-cycle pulse, results valid in that cycle
//   count     out  shift amount applied (0..32)
//   data_out  out  normalized operand
//   zero      out  operand was all-zero

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module shift_norm #(
  parameter int SA_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [`REG_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [SA_WIDTH:0]     count,
  output logic [`REG_WIDTH-1:0] data_out,
  output logic                  zero
);

  localparam int MSB = `REG_WIDTH - 1;

  // Largest shift the loop will apply to a nonzero operand.
  localparam logic [SA_WIDTH:0] COUNT_MAX  = {1'b0, {SA_WIDTH{1'b1}}};
  localparam logic [SA_WIDTH:0] COUNT_ONE  = (SA_WIDTH+1)'(1);
  // Count reported for an all-zero operand in leading-zero mode.
  localparam logic [SA_WIDTH:0] COUNT_ZERO = (SA_WIDTH+1)'(`REG_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;

  logic              msb_stop;
  logic              stop;
  logic [SA_WIDTH:0] zero_count;

`ifdef SHIFT_NORM_SIGNED_EN
  // A zero operand in signed mode has all but one bit redundant.
  localparam logic [SA_WIDTH:0] COUNT_ZERO_S = (SA_WIDTH+1)'(`REG_WIDTH - 1);

  logic mode_q;

  // Signed operand is normalized once the top two bits differ.
  assign msb_stop   = mode_q ? (data_out[MSB] != data_out[MSB-1]) : data_out[MSB];
  assign zero_count = mode ? COUNT_ZERO_S : COUNT_ZERO;
`else
  logic mode_unused;

  assign mode_unused = mode;
  assign msb_stop    = data_out[MSB];
  assign zero_count  = COUNT_ZERO;
`endif

  assign stop = msb_stop || (count == COUNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      data_out <= '0;
      zero     <= 1'b0;
`ifdef SHIFT_NORM_SIGNED_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_out <= data_in;
            busy     <= 1'b1;
`ifdef SHIFT_NORM_SIGNED_EN
            mode_q   <= mode;
`endif
            // An all-zero operand never meets the stop condition on its
            // own, so it bypasses the shift loop entirely.
            if (data_in == '0) begin
              zero  <= 1'b1;
              count <= zero_count;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              zero  <= 1'b0;
              count <= '0;
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (stop) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            data_out <= {data_out[MSB-1:0], 1'b0};
            count    <= count + COUNT_ONE;
          end
        end

        DONE: begin
          // start is not sampled here, so a request in this cycle is dropped.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_norm.sv
// tb/tb_shift_norm.sv - randomized self-checking bench for shift_norm

module tb_shift_norm;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] data_out;
  logic        zero;

  int checks;
  int errors;
  int done_cnt;

  shift_norm #(.SA_WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .data_out (data_out),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: count leading zeros, or sign bits beyond the first, by
  // scanning the operand from the top.
  function automatic void model(input logic [31:0] x, input logic m,
                                output int n, output logic [31:0] y, output logic z);
    logic eff_m;
`ifdef SHIFT_NORM_SIGNED_EN
    eff_m = m;
`else
    eff_m = 1'b0;
`endif
    z = (x == 32'd0);
    n = 0;
    if (z) begin
      n = eff_m ? 31 : 32;
      y = 32'd0;
    end else begin
      if (!eff_m) begin
        while (x[31-n] == 1'b0) n++;
      end else begin
        while (n < 31 && x[30-n] == x[31]) n++;
      end
      y = x << n;
    end
  endfunction

  // Runs one operation. If poke > 0, start is raised with data_in=1 on the
  // poke-th cycle after acceptance, which the DUT must ignore.
  task automatic run_op(input logic [31:0] x, input logic m, input string tag, input int poke);
    int          n;
    int          lat;
    int          k;
    int          d0;
    logic [31:0] y;
    logic        z;
    model(x, m, n, y, z);
    lat = z ? 1 : n + 2;
    @(negedge clk);
    check({tag, "_idle"}, busy, 1'b0);
    start   = 1'b1;
    data_in = x;
    mode    = m;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = $urandom;
    mode    = 1'($urandom);
    d0      = done_cnt;
    k       = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      start   = (k == poke);
      data_in = start ? 32'd1 : $urandom;
      if (done) break;
    end
    check({tag, "_lat"}, k, lat);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_count"}, count, n);
    check({tag, "_data"}, data_out, y);
    check({tag, "_zero"}, zero, z);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_idle2"}, busy, 1'b0);
    check({tag, "_hold"}, {zero, count, data_out}, {z, 6'(n), y});
    check({tag, "_ndone"}, done_cnt - d0, 1);
  endtask

  initial begin
    int          k;
    int          j;
    int          d0;
    logic [31:0] x;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    data_in  = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 6'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_zero", zero, 1'b0);
    rst = 1'b0;

    run_op(32'h0001_0000, 1'b0, "d_16k", 0);
    run_op(32'h8000_0001, 1'b0, "d_msb", 0);
    run_op(32'h0000_0000, 1'b0, "d_zero0", 0);
    run_op(32'h0000_0000, 1'b1, "d_zero1", 0);
    run_op(32'hFFFF_8000, 1'b1, "d_neg", 0);
    run_op(32'hFFFF_FFFF, 1'b1, "d_m1", 0);
    run_op(32'h0000_0001, 1'b1, "d_one1", 0);
    run_op(32'h0000_0001, 1'b0, "d_max", 0);
    run_op(32'h0001_0000, 1'b0, "d_busy_start", 3);
    run_op(32'h0001_0000, 1'b0, "d_done_start", 17);

    // start held high across DONE is re-accepted on the following idle cycle
    @(negedge clk);
    start   = 1'b1;
    data_in = 32'h8000_0001;
    mode    = 1'b0;
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (done) break;
    end
    check("held_lat1", k, 2);
    j = 0;
    while (j < 10) begin
      @(negedge clk);
      j++;
      if (done) break;
    end
    check("held_lat2", j, 3);
    start = 1'b0;
    check("held_data", data_out, 32'h8000_0001);
    @(negedge clk);

    // asynchronous reset in the middle of a long shift
    @(negedge clk);
    start   = 1'b1;
    data_in = 32'h0000_0001;
    mode    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_count", count, 6'd0);
    check("arst_data", data_out, 32'd0);
    check("arst_zero", zero, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_nodone", done_cnt - d0, 0);
    run_op(32'h4000_0000, 1'b0, "post_rst", 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       x = 32'd0;
        1:       x = $urandom >> $urandom_range(0, 31);
        2:       x = ~($urandom >> $urandom_range(0, 31));
        3:       x = 32'd1 << $urandom_range(0, 31);
        default: x = $urandom;
      endcase
      run_op(x, 1'($urandom), "rnd", int'($urandom_range(0, 35)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_norm.md
SHIFT_NORM -- requirements
Module: shift_norm

Interface
REQ-001 The block SHALL use parameter SA_WIDTH, default 5, the shift-count field width; the data width is `REG_WIDTH (32) from the ALU defines.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 mode  input  1  0 = count leading zeros (unsigned); 1 = count redundant sign bits (signed).
REQ-006 data_in  input  `REG_WIDTH  operand; captured on the edge that accepts start.
REQ-007 busy  output  1  high in SHIFT and DONE.
REQ-008 done  output  1  one-cycle pulse; result outputs are valid in that cycle.
REQ-009 count  output  SA_WIDTH+1  shift amount applied (0..32).
REQ-010 data_out  output  `REG_WIDTH  normalized operand.
REQ-011 zero  output  1  operand was all-zero.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; busy SHALL be 1 in SHIFT and DONE, and done SHALL be 1 only in DONE.
REQ-013 IDLE with start=1: capture data_in and mode, clear the count, then go to SHIFT; if data_in==0, go directly to DONE with zero=1 and count=32 (mode 0) or 31 (mode 1).
REQ-014 The stop condition SHALL be: mode 0, data[31]==1; mode 1, data[31]!=data[30]; either mode, count reached the maximum (31).
REQ-015 SHIFT, each cycle: if the stop condition holds, go to DONE; otherwise shift data left by 1 (LSB fill 0) and increment the count.
REQ-016 Latency: done SHALL assert n+2 cycles after the accepting edge for a nonzero operand with final count n, and 1 cycle after for a zero operand.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; count, data_out and zero SHALL hold until the next accepted start.
REQ-018 A start asserted while busy=1 SHALL be ignored and not queued; a start in the same cycle as DONE SHALL be ignored.
REQ-019 A start held high continuously SHALL be re-accepted on the first IDLE cycle after DONE.
REQ-020 Final data_out SHALL equal the captured operand shifted left by count, truncated to `REG_WIDTH.
REQ-021 Mode-1 result for -1 (0xFFFFFFFF) SHALL be count=31, data_out=0x80000000, zero=0.

Reset
REQ-022 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-023 Reset values: busy=0, done=0, count=0, data_out=0, zero=0.
REQ-024 rst asserted mid-operation SHALL abort the operation without producing a done pulse.
REQ-025 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 SHIFT_NORM_SIGNED_EN defined: mode input honoured as specified above.
REQ-027 SHIFT_NORM_SIGNED_EN undefined: mode input ignored and treated as 0; only leading-zero behaviour exists; zero-operand count is always 32; the sign-compare logic is absent.

Verification
REQ-028 Mode 0, data_in=0x00010000 -> done 17 cycles after accept, count=15, data_out=0x80000000, zero=0.
REQ-029 Mode 0, data_in=0x80000001 -> done 2 cycles after accept, count=0, data_out=0x80000001.
REQ-030 Mode 0, data_in=0 -> done 1 cycle after accept, count=32, zero=1, data_out=0; mode 1, data_in=0 -> count=31, zero=1 (macro defined).
REQ-031 Mode 1, data_in=0xFFFF8000 -> count=16, data_out=0x80000000; data_in=0xFFFFFFFF -> count=31, data_out=0x80000000.
REQ-032 Second start pulse during busy with data_in=0x1 -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-033 rst pulsed mid-SHIFT (operand 0x00000001) -> outputs return to 0 asynchronously, no done; next start with 0x40000000 yields count=1.
